// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
// Optional saturating match counter is built when SEQ_DET_CNT_EN is defined.
module seq_detect_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0001_1110,
    parameter int                 RST_LEN = 5,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               y
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    localparam int FILL_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [FILL_W-1:0]  fill_q;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               armed;
    logic               len_ok;
    logic               hit;
    int                 l_eff;

    // Compare the candidate window (history plus the incoming bit) against the
    // pattern over only the low L bits.
    always_comb begin
        l_eff  = (int'(len_q) > MAX_LEN) ? MAX_LEN : int'(len_q);
        len_ok = (l_eff >= 2);
        armed  = ((int'(fill_q) + 1) >= l_eff);
        window = {hist_q[MAX_LEN-2:0], x};
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < l_eff);
        end
        hit = (((window ^ pat_q) & mask) == '0);
        y   = !rst && en && !cfg_load && len_ok && armed && hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= RST_PAT;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_load) begin
            pat_q  <= cfg_pat;
            len_q  <= cfg_len;
            ovl_q  <= cfg_overlap;
            hist_q <= '0;
            fill_q <= '0;
        end else if (en) begin
            if (y && !ovl_q) begin
                // Non-overlapping: the next occurrence must be built from fresh bits.
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= window;
                if (int'(fill_q) < MAX_LEN) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
        end
    end

`ifdef SEQ_DET_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            match_cnt <= '0;
        end else if (y) begin
            match_cnt <= sat_inc(match_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: the driver queues the expected y (and
// counter value when SEQ_DET_CNT_EN is defined) for every cycle; a monitor checks them.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       x;
    logic       en;
    logic       cfg_load;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       y;
`ifdef SEQ_DET_CNT_EN
    logic [1:0] match_cnt;
`endif

    seq_detect_param #(.CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_pat     (cfg_pat),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .y           (y)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    typedef struct {
        int   step;
        logic y;
        int   cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue what the DUT must show in that cycle.
    // ecnt < 0 means the counter is not checked in that cycle.
    task automatic drive(input logic r, input logic e_in, input logic xb,
                         input logic ld, input logic ey, input int ecnt);
        exp_t t;
        @(posedge clk);
        #1;
        rst      = r;
        en       = e_in;
        x        = xb;
        cfg_load = ld;
        step++;
        t.step = step;
        t.y    = ey;
        t.cnt  = ecnt;
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (y !== e.y) begin
                bad++;
                $display("FAIL y step=%0d got=%b want=%b", e.step, y, e.y);
            end
`ifdef SEQ_DET_CNT_EN
            if (e.cnt >= 0) begin
                total++;
                if (match_cnt !== e.cnt[1:0]) begin
                    bad++;
                    $display("FAIL match_cnt step=%0d got=%0d want=%0d", e.step, match_cnt, e.cnt);
                end
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; x = 1'b0; cfg_load = 1'b0;
        cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;

        // Reset: y held low even with en=1 and x=1
        drive(1, 1, 1, 0, 0, -1);
        drive(1, 1, 1, 0, 0, -1);
        drive(0, 0, 0, 0, 0, 0);

        // Reset defaults 11110: match on 5th bit only
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 1, -1);
        drive(0, 0, 0, 0, 0, 1);

        // en=0 gap between bits 2 and 3
        drive(1, 0, 0, 0, 0, -1);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 0, 1, 0, 0, -1);
        drive(0, 0, 0, 0, 0, -1);
        drive(0, 0, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 1, -1);
        drive(0, 0, 0, 0, 0, 1);

        // Overlap continues: 1,1,1,1 shifts in without a match, history ends ...1111
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        // cfg_load with en=1, x=0 would otherwise complete 11110
        cfg_pat = 8'b0001_1110; cfg_len = 4'd5; cfg_overlap = 1'b1;
        drive(0, 1, 0, 1, 0, 1);
        // History was cleared, so another 0 cannot complete the pattern
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 1, -1);
        drive(0, 0, 0, 0, 0, 1);

        // Pattern 1010, len 4, overlapping (load while en=0)
        cfg_pat = 8'b0000_1010; cfg_len = 4'd4; cfg_overlap = 1'b1;
        drive(0, 0, 0, 1, 0, -1);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 1, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 1, -1);
        drive(0, 0, 0, 0, 0, 2);

        // Same pattern, non-overlapping
        cfg_overlap = 1'b0;
        drive(0, 0, 0, 1, 0, -1);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 1, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 1, -1);
        drive(0, 0, 0, 0, 0, 2);

        // Length 1 disables detection
        cfg_pat = 8'b0000_0001; cfg_len = 4'd1; cfg_overlap = 1'b1;
        drive(0, 0, 0, 1, 0, -1);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, -1);

        // Length 9 clamps to 8: pattern 10100101 matches on the 8th bit
        cfg_pat = 8'b1010_0101; cfg_len = 4'd9; cfg_overlap = 1'b0;
        drive(0, 0, 0, 1, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 0, -1);
        drive(0, 1, 0, 0, 0, -1);
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 0, 0, -1);
        drive(0, 1, 1, 0, 1, -1);

        // Pattern 11, len 2, overlapping: six 1s give five matches, counter saturates at 3
        cfg_pat = 8'b0000_0011; cfg_len = 4'd2; cfg_overlap = 1'b1;
        drive(0, 0, 0, 1, 0, -1);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 1, -1);
        drive(0, 1, 1, 0, 1, -1);
        drive(0, 1, 1, 0, 1, -1);
        drive(0, 1, 1, 0, 1, -1);
        drive(0, 1, 1, 0, 1, -1);
        // rst mid-stream: y forced low, counter cleared, defaults restored
        drive(1, 1, 1, 0, 0, 3);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, -1);

        drive(0, 0, 0, 0, 0, -1);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
